// File: rtl/jellyvl_divider_pkg.sv
// jellyvl_divider_pkg: per-request tag shared by the sign-prep and sign-fixup stages of the signed divider
package jellyvl_divider_pkg;
  typedef struct packed {
    logic sign_q;
    logic sign_r;
    logic divzero;
  } t_div_tag;
endpackage

// File: rtl/jellyvl_divider_tag_fifo.sv
// jellyvl_divider_tag_fifo: synchronous tag FIFO with registered count and unregistered read data
module jellyvl_divider_tag_fifo
  import jellyvl_divider_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cke,
  input  t_div_tag      s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output t_div_tag      m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] count
);
  t_div_tag mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  assign s_ready = cnt_q < CW'(DEPTH);
  assign m_valid = cnt_q != '0;
  assign m_data  = mem_q[rd_q];
  assign count   = cnt_q;
  assign push    = cke && s_valid && s_ready;
  assign pop     = cke && m_valid && m_ready;
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/jellyvl_divider_signed_fixup.sv
// jellyvl_divider_signed_fixup: applies queued sign/divzero tags to unsigned divider results; JELLYVL_DIVIDER_SIGNED_FIXUP_ERRCNT_EN enables the divzero counter
module jellyvl_divider_signed_fixup
  import jellyvl_divider_pkg::*;
#(
  parameter int QUOTIENT_WIDTH  = 32,
  parameter int REMAINDER_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cke,
  input  logic                               t_sign_q,
  input  logic                               t_sign_r,
  input  logic                               t_divzero,
  input  logic                               t_valid,
  output logic                               t_ready,
  input  logic [QUOTIENT_WIDTH-1:0]          s_quotient,
  input  logic [REMAINDER_WIDTH-1:0]         s_remainder,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [QUOTIENT_WIDTH-1:0]          m_quotient,
  output logic [REMAINDER_WIDTH-1:0]         m_remainder,
  output logic                               m_divzero,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    tag_count,
  output logic [15:0]                        err_count
);
  t_div_tag tag_in, tag;
  logic tag_valid, accept;
  logic [QUOTIENT_WIDTH-1:0] quot_d, quot_q;
  logic [REMAINDER_WIDTH-1:0] rem_d, rem_q;
  logic valid_q, divzero_q;
  assign tag_in  = '{sign_q: t_sign_q, sign_r: t_sign_r, divzero: t_divzero};
  assign s_ready = cke && tag_valid && (!valid_q || m_ready);
  assign accept  = s_valid && s_ready;
  jellyvl_divider_tag_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk    (clk),
    .rst    (rst),
    .cke    (cke),
    .s_data (tag_in),
    .s_valid(t_valid),
    .s_ready(t_ready),
    .m_data (tag),
    .m_valid(tag_valid),
    .m_ready(accept),
    .count  (tag_count)
  );
  always_comb begin
    quot_d = tag.divzero ? '1 : (tag.sign_q ? -s_quotient : s_quotient);
    rem_d  = tag.sign_r ? -s_remainder : s_remainder;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      divzero_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else if (cke) begin
      if (accept) begin
        valid_q   <= 1'b1;
        divzero_q <= tag.divzero;
        quot_q    <= quot_d;
        rem_q     <= rem_d;
      end else if (m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end
  assign m_valid     = valid_q;
  assign m_divzero   = divzero_q;
  assign m_quotient  = quot_q;
  assign m_remainder = rem_q;
`ifdef JELLYVL_DIVIDER_SIGNED_FIXUP_ERRCNT_EN
  logic [15:0] err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else if (cke && valid_q && m_ready && divzero_q && err_q != 16'hffff) err_q <= err_q + 16'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_jellyvl_divider_signed_fixup.sv
// tb_jellyvl_divider_signed_fixup: vector table, directed corner sequences and random traffic against a queue model
module tb_jellyvl_divider_signed_fixup;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst, cke, t_sign_q, t_sign_r, t_divzero, t_valid, t_ready;
  logic [7:0] s_quotient, s_remainder, m_quotient, m_remainder;
  logic s_valid, s_ready, m_divzero, m_valid, m_ready;
  logic [2:0] tag_count;
  logic [15:0] err_count;
  int checks = 0, errors = 0;
  typedef struct packed {logic sq; logic sr; logic dz;} tag_t;
  typedef struct {logic sq, sr, dz; logic [7:0] q, r, eq, er; logic ed;} vec_t;
  tag_t tq[$];
  logic mv, md;
  logic [7:0] mq, mrem;
  logic [15:0] ec;
  vec_t vt[8];

  jellyvl_divider_signed_fixup #(.QUOTIENT_WIDTH(8), .REMAINDER_WIDTH(8), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cke(cke),
    .t_sign_q(t_sign_q), .t_sign_r(t_sign_r), .t_divzero(t_divzero), .t_valid(t_valid), .t_ready(t_ready),
    .s_quotient(s_quotient), .s_remainder(s_remainder), .s_valid(s_valid), .s_ready(s_ready),
    .m_quotient(m_quotient), .m_remainder(m_remainder), .m_divzero(m_divzero), .m_valid(m_valid), .m_ready(m_ready),
    .tag_count(tag_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic tv, input logic sq, input logic sr, input logic dz,
                      input logic sv, input logic [7:0] q, input logic [7:0] r, input logic mrdy);
    logic exp_t, exp_s;
    tag_t tg;
    @(negedge clk);
    cke = c; t_valid = tv; t_sign_q = sq; t_sign_r = sr; t_divzero = dz;
    s_valid = sv; s_quotient = q; s_remainder = r; m_ready = mrdy;
    #1;
    exp_t = tq.size() < D;
    exp_s = c && tq.size() > 0 && (!mv || mrdy);
    chk("t_ready", t_ready, exp_t);
    chk("s_ready", s_ready, exp_s);
    chk("tag_count", tag_count, tq.size());
    chk("m_valid", m_valid, mv);
    chk("m_quotient", m_quotient, mq);
    chk("m_remainder", m_remainder, mrem);
    chk("m_divzero", m_divzero, md);
`ifdef JELLYVL_DIVIDER_SIGNED_FIXUP_ERRCNT_EN
    chk("err_count", err_count, ec);
`else
    chk("err_count", err_count, 0);
`endif
    @(posedge clk);
    if (c) begin
      if (mv && mrdy && md && ec != 16'hffff) ec++;
      if (sv && exp_s) begin
        tg   = tq.pop_front();
        mv   = 1'b1;
        md   = tg.dz;
        mq   = tg.dz ? 8'hff : (tg.sq ? 8'(9'd256 - {1'b0, q}) : q);
        mrem = tg.sr ? 8'(9'd256 - {1'b0, r}) : r;
      end else if (mrdy) mv = 1'b0;
      if (tv && exp_t) tq.push_back(tag_t'({sq, sr, dz}));
    end
    #1;
  endtask

  task automatic idle(input logic mrdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, mrdy);
  endtask

  task automatic push(input logic sq, input logic sr, input logic dz);
    step(1'b1, 1'b1, sq, sr, dz, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cke = 1'b1; t_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tq.delete();
    mv = 1'b0; md = 1'b0; mq = '0; mrem = '0; ec = '0;
  endtask

  initial begin
    rst = 1'b1; cke = 1'b0; t_valid = 1'b0; t_sign_q = 1'b0; t_sign_r = 1'b0; t_divzero = 1'b0;
    s_valid = 1'b0; s_quotient = '0; s_remainder = '0; m_ready = 1'b0;
    vt[0] = '{1'b1, 1'b1, 1'b0, 8'h03, 8'h01, 8'hfd, 8'hff, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 8'hff, 8'h05, 8'hff, 8'hfb, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b0, 8'h03, 8'h01, 8'h03, 8'h01, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b0, 8'h03, 8'h01, 8'hfd, 8'h01, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h05, 8'hff, 8'h05, 1'b1};
    vt[7] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    do_reset();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_tag_count", tag_count, 0);
    chk("rst_m_quotient", m_quotient, 0);
    chk("rst_m_remainder", m_remainder, 0);
    idle(1'b1);

    foreach (vt[i]) begin
      push(vt[i].sq, vt[i].sr, vt[i].dz);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, vt[i].q, vt[i].r, 1'b1);
      chk("vec_m_valid", m_valid, 1);
      chk("vec_m_quotient", m_quotient, vt[i].eq);
      chk("vec_m_remainder", m_remainder, vt[i].er);
      chk("vec_m_divzero", m_divzero, vt[i].ed);
    end
    idle(1'b1);
    idle(1'b1);

    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 1'b0);
    chk("full_count", tag_count, 4);
    chk("full_t_ready", t_ready, 0);
    push(1'b1, 1'b1, 1'b0);
    chk("full_held_count", tag_count, 4);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 8'h01, 1'b1);
    chk("full_pop_count", tag_count, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 8'h02, 1'b1);
    chk("push_pop_count", tag_count, 3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(i), 8'h03, 1'b1);
    idle(1'b1);

    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 8'h05, 1'b1);
      chk("empty_s_ready", s_ready, 0);
      chk("empty_m_valid", m_valid, 0);
    end

    push(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 8'h02, 1'b0);
      chk("stall_s_ready", s_ready, 0);
      chk("stall_m_quotient", m_quotient, 8'hfb);
      chk("stall_m_valid", m_valid, 1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 8'h02, 1'b1);
    chk("resume_m_quotient", m_quotient, 8'h09);
    chk("resume_m_remainder", m_remainder, 8'h02);
    idle(1'b1);

    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 8'h00, 1'b0);
    chk("pre_rst_count", tag_count, 2);
    chk("pre_rst_m_valid", m_valid, 1);
    do_reset();
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_count", tag_count, 0);
    chk("post_rst_t_ready", t_ready, 1);
    idle(1'b1);

    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
    chk("cke_low_count", tag_count, 0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
           1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
